// File: rtl/uart_alu_if.sv
// -----------------------------------------------------------------------------
// uart_alu_if
//
// Control stage between the UART receiver and the UART transmitter.
// It collects three received bytes in order (operand A, operand B, opcode)
// and drives them as registered operands to an external combinational ALU.
// It then captures the ALU result and hands that byte to the transmitter
// with a start/done handshake.
//
// Optional feature (define the macro to enable it):
//   UART_IF_TIMEOUT_EN  inter-byte timeout. A partial frame that sits in
//                       GET_B or GET_OP for TIMEOUT_CYCLES cycles is dropped.
//
// Ports:
//   i_clock       system clock
//   i_reset       synchronous, active-high reset
//   i_rx_done     receiver done flag (a level that may stay high for
//                 several cycles per byte)
//   i_rx_data     received byte, valid while i_rx_done is high
//   i_alu_result  combinational ALU result
//   i_tx_done     transmitter finished the current byte (pulse or level)
//   o_alu_a       operand A to the ALU
//   o_alu_b       operand B to the ALU
//   o_alu_op      opcode to the ALU (low NB_OP bits of the third byte)
//   o_tx_start    one-cycle pulse that requests a transmission
//   o_tx_data     byte to transmit, held until i_tx_done
//   o_busy        high from the first accepted byte until the result is sent
//   o_overrun     one-cycle pulse: a byte arrived while not accepting
//   o_timeout     one-cycle pulse: a partial frame was discarded
//
// Handshakes:
//   Receive side: a byte is accepted on the rising edge of i_rx_done. That is
//   the cycle where i_rx_done=1 and its registered copy is 0. i_rx_data is
//   sampled in that same cycle, so a held level counts once.
//   Transmit side: o_tx_start pulses for exactly one cycle, with o_tx_data
//   already valid. o_tx_data stays stable until i_tx_done is seen in
//   WAIT_TX. i_tx_done is ignored in every other state.
// -----------------------------------------------------------------------------
module uart_alu_if #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int NB_TIMEOUT     = 20
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_overrun,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        ST_GET_A   = 3'd0,
        ST_GET_B   = 3'd1,
        ST_GET_OP  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_LATCH   = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    state_t             r_state;
    logic               r_rx_done_q;
    logic [NB_DATA-1:0] r_alu_a;
    logic [NB_DATA-1:0] r_alu_b;
    logic [NB_OP-1:0]   r_alu_op;
    logic               r_tx_start;
    logic [NB_DATA-1:0] r_tx_data;
    logic               r_busy;
    logic               r_overrun;
    logic               r_timeout;

    logic               w_rx_event;
    logic               w_expired;

    // Rising edge of the receiver's done level.
    assign w_rx_event = i_rx_done & ~r_rx_done_q;

`ifdef UART_IF_TIMEOUT_EN
    logic [NB_TIMEOUT-1:0] r_timer;
    logic                  w_waiting;

    assign w_waiting = (r_state == ST_GET_B) || (r_state == ST_GET_OP);
    // An accepted byte in the expiry cycle takes priority over the timeout.
    assign w_expired = w_waiting && !w_rx_event &&
                       (r_timer == NB_TIMEOUT'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_timer <= '0;
        end else if (w_rx_event || !w_waiting || w_expired) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + NB_TIMEOUT'(1);
        end
    end
`else
    // Without the timeout, GET_B and GET_OP wait indefinitely.
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_GET_A;
            r_rx_done_q <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_rx_done_q <= i_rx_done;
            // Pulse outputs default low and are raised for a single cycle.
            r_tx_start  <= 1'b0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;

            case (r_state)
                ST_GET_A: begin
                    if (w_rx_event) begin
                        r_alu_a <= i_rx_data;
                        r_busy  <= 1'b1;
                        r_state <= ST_GET_B;
                    end
                end

                ST_GET_B: begin
                    if (w_rx_event) begin
                        r_alu_b <= i_rx_data;
                        r_state <= ST_GET_OP;
                    end else if (w_expired) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_GET_A;
                    end
                end

                ST_GET_OP: begin
                    if (w_rx_event) begin
                        // Opcode bits above NB_OP are dropped.
                        r_alu_op <= i_rx_data[NB_OP-1:0];
                        r_state  <= ST_EXEC;
                    end else if (w_expired) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_GET_A;
                    end
                end

                // The operands are already stable. This cycle lets the
                // external ALU settle before its result is captured.
                ST_EXEC: begin
                    if (w_rx_event) begin
                        r_overrun <= 1'b1;
                    end
                    r_state <= ST_LATCH;
                end

                ST_LATCH: begin
                    if (w_rx_event) begin
                        r_overrun <= 1'b1;
                    end
                    r_tx_data  <= i_alu_result;
                    r_tx_start <= 1'b1;
                    r_state    <= ST_WAIT_TX;
                end

                ST_WAIT_TX: begin
                    // A byte that arrives together with i_tx_done is still
                    // dropped. The frame ends first, and the receiver's edge
                    // has been consumed.
                    if (w_rx_event) begin
                        r_overrun <= 1'b1;
                    end
                    if (i_tx_done) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_GET_A;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_GET_A;
                end
            endcase
        end
    end

    assign o_alu_a    = r_alu_a;
    assign o_alu_b    = r_alu_b;
    assign o_alu_op   = r_alu_op;
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_busy     = r_busy;
    assign o_overrun  = r_overrun;
    assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_uart_alu_if.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_if
//
// Directed bench for uart_alu_if in its default build (no inter-byte timeout).
// The external ALU is modelled as ADD on opcode 0x20 and 0x00 otherwise.
// Every expected value is a hand-computed constant.
// -----------------------------------------------------------------------------
module tb_uart_alu_if;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_done = 1'b0;
    logic [7:0] alu_result;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       overrun;
    logic       timeout;

    int tests = 0;
    int fails = 0;
    int n_start = 0;
    int n_over = 0;
    int n_tmo = 0;

    always #5 clk = ~clk;

    // External ALU model: ADD on opcode 0x20, zero otherwise.
    assign alu_result = (alu_op == 6'h20) ? 8'(alu_a + alu_b) : 8'h00;

    uart_alu_if dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_rx_done    (rx_done),
        .i_rx_data    (rx_data),
        .i_alu_result (alu_result),
        .i_tx_done    (tx_done),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .o_busy       (busy),
        .o_overrun    (overrun),
        .o_timeout    (timeout)
    );

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (tx_start) n_start++;
        if (overrun)  n_over++;
        if (timeout)  n_tmo++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One low cycle first, so that every byte presents a fresh rising edge.
    task automatic send(input logic [7:0] d, input int hold);
        tick();
        rx_data = d;
        rx_done = 1'b1;
        repeat (hold) tick();
        rx_done = 1'b0;
    endtask

    // Send one frame with single-cycle done pulses. Check the start latency,
    // the single pulse and the result byte.
    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] exp);
        int s0;
        int lat;
        s0 = n_start;
        lat = 0;
        send(a, 1);
        send(b, 1);
        send(op, 1);
        // The third event edge has just passed (state EXEC). tx_start is
        // expected two edges later.
        while (!tx_start && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_start_latency"}, lat, 2);
        check({tag, "_tx_data"}, tx_data, exp);
        tick();
        check({tag, "_start_low"}, tx_start, 0);
        check({tag, "_start_count"}, n_start - s0, 1);
    endtask

    task automatic finish_tx(input string tag);
        check({tag, "_busy_before_done"}, busy, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check({tag, "_busy_after_done"}, busy, 0);
    endtask

    initial begin
        int s0;
        int o0;
        int t0;

        // Reset state.
        rst = 1'b1;
        repeat (3) tick();
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;
        tick();

        // Basic frame: 5 + 3 = 8.
        run_frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
        check("add_alu_a", alu_a, 8'h05);
        check("add_alu_b", alu_b, 8'h03);
        check("add_alu_op", alu_op, 6'h20);
        finish_tx("add");

        // Done held high for 16 cycles per byte: each byte counts once. FF + 01 wraps to 00.
        s0 = n_start;
        send(8'hFF, 16);
        send(8'h01, 16);
        send(8'h20, 16);
        check("held_start_count", n_start - s0, 1);
        check("held_tx_data", tx_data, 8'h00);
        check("held_alu_a", alu_a, 8'hFF);
        check("held_alu_b", alu_b, 8'h01);

        // A fourth byte during WAIT_TX is dropped with a single overrun pulse.
        o0 = n_over;
        send(8'hAA, 1);
        tick();
        tick();
        check("ovr_count", n_over - o0, 1);
        check("ovr_tx_data", tx_data, 8'h00);
        check("ovr_alu_a", alu_a, 8'hFF);
        finish_tx("ovr");
        run_frame("after_ovr", 8'h02, 8'h02, 8'h20, 8'h04);
        finish_tx("after_ovr");

        // Reset in the middle of a frame clears everything.
        send(8'h33, 1);
        send(8'h44, 1);
        tick();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_b", alu_b, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tx_data", tx_data, 0);
        rst = 1'b0;
        run_frame("post_rst", 8'h10, 8'h01, 8'h20, 8'h11);
        check("post_rst_alu_a", alu_a, 8'h10);
        finish_tx("post_rst");

        // Opcode bits above bit 5 are dropped: 0xE0 becomes 0x20.
        run_frame("opmask", 8'h01, 8'h02, 8'hE0, 8'h03);
        check("opmask_alu_op", alu_op, 6'h20);
        finish_tx("opmask");

        // Long idle in GET_B: no timeout in the default build.
        t0 = n_tmo;
        send(8'h07, 1);
        repeat (60) tick();
        check("idle_timeout_count", n_tmo - t0, 0);
        check("idle_busy", busy, 1);
        check("idle_alu_a", alu_a, 8'h07);
        s0 = n_start;
        send(8'h01, 1);
        send(8'h20, 1);
        repeat (4) tick();
        check("idle_start_count", n_start - s0, 1);
        check("idle_tx_data", tx_data, 8'h08);
        finish_tx("idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
